// File: rtl/fsk_demod_p_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fsk_demod_p_if                                                             |
// | Sample input and demodulated outputs of the zero-crossing FSK demodulator. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fsk_demod_p_if #(
  parameter int W     = 8,
  parameter int CNT_W = 8
);
  logic [W-1:0]     signal_in;
  logic             borda;
  logic             bitout;
  logic             bitsinc;
  logic [CNT_W-1:0] half_len;
  logic             carrier;

  modport master (
    output signal_in,
    input  borda, bitout, bitsinc, half_len, carrier
  );

  modport slave (
    input  signal_in,
    output borda, bitout, bitsinc, half_len, carrier
  );
endinterface
`default_nettype wire

// File: rtl/fsk_demod_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fsk_demod_p                                                                |
// | Zero-crossing FSK demodulator: half-period measurement, glitch rejection,  |
// | N-of-N bit confirmation and carrier-loss detection.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fsk_demod_p #(
  parameter int W        = 8,
  parameter int CNT_W    = 8,
  parameter int THRESH   = 24,
  parameter int MIN_HALF = 4,
  parameter int MAX_HALF = 200,
  parameter int NCONFIRM = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fsk_demod_p_if.slave bus
);

  generate
    if (!(MIN_HALF >= 1 && MIN_HALF <= THRESH && THRESH < MAX_HALF &&
          MAX_HALF < (2 ** CNT_W) - 1 && NCONFIRM >= 1 && NCONFIRM <= 7)) begin : g_bad_params
      $error("fsk_demod_p: illegal parameter combination");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_min_half = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] c_thresh   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] c_tmo      = CNT_W'(MAX_HALF - 1);
  localparam logic [2:0]       c_nconf    = 3'(NCONFIRM);

  logic             r_s1, r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_run;
  logic             r_last_cls;
  logic             r_stale;
  logic             r_borda, r_bitout, r_bitsinc, r_carrier;
  logic [CNT_W-1:0] r_half_len;

  logic             w_raw_edge;
  logic [CNT_W-1:0] w_m;
  logic             w_accept;
  logic             w_cls;
  logic [2:0]       w_run_next;

  assign w_raw_edge = r_s1 ^ r_s2;
  assign w_m        = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + CNT_W'(1);
  assign w_accept   = w_raw_edge && (w_m >= c_min_half);
  assign w_cls      = (w_m > c_thresh);
  // A class change restarts confirmation at one; a repeat saturates at NCONFIRM.
  assign w_run_next = (w_cls != r_last_cls) ? 3'd1 :
                      (r_run >= c_nconf)    ? c_nconf : r_run + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_cnt      <= '0;
      r_run      <= 3'd0;
      r_last_cls <= 1'b0;
      r_stale    <= 1'b1;
      r_borda    <= 1'b0;
      r_bitout   <= 1'b0;
      r_bitsinc  <= 1'b0;
      r_carrier  <= 1'b0;
      r_half_len <= '0;
    end else begin
      r_s1      <= bus.signal_in[W-1];
      r_s2      <= r_s1;
      r_borda   <= 1'b0;
      r_bitsinc <= 1'b0;
      if (w_accept) begin
        r_borda    <= 1'b1;
        r_half_len <= w_m;
        r_cnt      <= '0;
        if (r_stale) begin
          // First crossing after silence only re-aligns the measurement.
          r_stale <= 1'b0;
        end else begin
          r_last_cls <= w_cls;
          r_run      <= w_run_next;
          if (w_run_next >= c_nconf) begin
            r_bitout  <= w_cls;
            r_bitsinc <= 1'b1;
            r_carrier <= 1'b1;
          end
        end
      end else begin
        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == c_tmo) begin
          r_carrier <= 1'b0;
          r_run     <= 3'd0;
          r_stale   <= 1'b1;
        end
      end
    end
  end

  assign bus.borda    = r_borda;
  assign bus.bitout   = r_bitout;
  assign bus.bitsinc  = r_bitsinc;
  assign bus.half_len = r_half_len;
  assign bus.carrier  = r_carrier;

endmodule
`default_nettype wire

// File: tb/tb_fsk_demod_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fsk_demod_p                                                             |
// | Directed and random FSK stimulus checked against a behavioural model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fsk_demod_p;
  localparam int W        = 8;
  localparam int CNT_W    = 8;
  localparam int THRESH   = 24;
  localparam int MIN_HALF = 4;
  localparam int MAX_HALF = 200;
  localparam int NCONFIRM = 2;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cur = 1'b0;

  fsk_demod_p_if #(.W(W), .CNT_W(CNT_W)) bus ();

  fsk_demod_p #(
    .W(W), .CNT_W(CNT_W), .THRESH(THRESH), .MIN_HALF(MIN_HALF),
    .MAX_HALF(MAX_HALF), .NCONFIRM(NCONFIRM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sign history, cycles since the last accepted crossing,
  // and the list of half-period classes measured since the last resync.
  bit m_s1 = 0, m_s2 = 0, m_stale = 1;
  int m_since = 0;
  bit m_cls_q[$];
  bit m_borda = 0, m_bitout = 0, m_bitsinc = 0, m_carrier = 0;
  int m_half_len = 0;

  always @(posedge clk) begin
    bit x, rs, cls, all_same;
    int m;
    x  = bus.signal_in[W-1];
    rs = rst;
    m_borda = 0;
    m_bitsinc = 0;
    if (rs) begin
      m_s1 = 0; m_s2 = 0; m_stale = 1; m_since = 0; m_cls_q.delete();
      m_bitout = 0; m_carrier = 0; m_half_len = 0;
    end else begin
      m = (m_since + 1 > SAT) ? SAT : m_since + 1;
      if (m_s1 != m_s2 && m >= MIN_HALF) begin
        m_borda = 1;
        m_half_len = m;
        m_since = 0;
        if (m_stale) begin
          m_stale = 0;
          m_cls_q.delete();
        end else begin
          cls = (m > THRESH);
          m_cls_q.push_back(cls);
          if (m_cls_q.size() > NCONFIRM) void'(m_cls_q.pop_front());
          all_same = (m_cls_q.size() == NCONFIRM);
          foreach (m_cls_q[i]) if (m_cls_q[i] != cls) all_same = 0;
          if (all_same) begin
            m_bitout = cls; m_bitsinc = 1; m_carrier = 1;
          end
        end
      end else begin
        if (m_since == MAX_HALF - 1) begin
          m_carrier = 0; m_stale = 1; m_cls_q.delete();
        end
        m_since = (m_since + 1 > SAT) ? SAT : m_since + 1;
      end
      m_s2 = m_s1;
      m_s1 = x;
    end
    #1;
    chk("borda",    int'(bus.borda),    int'(m_borda));
    chk("bitsinc",  int'(bus.bitsinc),  int'(m_bitsinc));
    chk("bitout",   int'(bus.bitout),   int'(m_bitout));
    chk("carrier",  int'(bus.carrier),  int'(m_carrier));
    chk("half_len", int'(bus.half_len), m_half_len);
  end

  task automatic put(input bit sg);
    @(posedge clk);
    #2;
    bus.signal_in = {sg, (W-1)'($urandom_range(0, (1 << (W-1)) - 1))};
  endtask

  task automatic half(input int p);
    cur = ~cur;
    repeat (p) put(cur);
  endtask

  task automatic square(input int p, input int n);
    repeat (n) half(p);
  endtask

  // Short sign flicker right after a crossing, then the rest of the half.
  task automatic glitch_half(input int p);
    cur = ~cur;
    put(cur); put(~cur); put(~cur);
    repeat (p - 3) put(cur);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2;
    chk({tag, "_borda"},    int'(bus.borda),    0);
    chk({tag, "_bitsinc"},  int'(bus.bitsinc),  0);
    chk({tag, "_bitout"},   int'(bus.bitout),   0);
    chk({tag, "_carrier"},  int'(bus.carrier),  0);
    chk({tag, "_half_len"}, int'(bus.half_len), 0);
    rst = 1'b0;
  endtask

  initial begin
    int gap;
    bit seen;
    bus.signal_in = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bitout",   int'(bus.bitout),   0);
    chk("rst_carrier",  int'(bus.carrier),  0);
    chk("rst_half_len", int'(bus.half_len), 0);
    rst = 1'b0;

    square(20, 8);
    chk("p20_half_len", int'(bus.half_len), 20);
    chk("p20_bitout",   int'(bus.bitout),   0);
    chk("p20_carrier",  int'(bus.carrier),  1);
    chk("model_p20_half_len", m_half_len, 20);

    square(40, 4);
    chk("p40_bitout",   int'(bus.bitout),   1);
    chk("p40_half_len", int'(bus.half_len), 40);
    chk("model_p40_bitout", int'(m_bitout), 1);

    half(20);
    cur = ~cur;
    repeat (30) put(cur);
    chk("lone_short_bitout",   int'(bus.bitout),   1);
    chk("lone_short_half_len", int'(bus.half_len), 20);
    chk("lone_short_carrier",  int'(bus.carrier),  1);
    repeat (10) put(cur);
    square(40, 3);

    square(24, 6);
    chk("p24_bitout",   int'(bus.bitout),   0);
    chk("p24_half_len", int'(bus.half_len), 24);
    square(25, 6);
    chk("p25_bitout",   int'(bus.bitout),   1);
    chk("p25_half_len", int'(bus.half_len), 25);

    square(40, 3);
    glitch_half(40);
    glitch_half(40);
    square(40, 2);
    chk("glitch_half_len", int'(bus.half_len), 40);
    chk("glitch_bitout",   int'(bus.bitout),   1);
    chk("glitch_carrier",  int'(bus.carrier),  1);

    // One last crossing, then silence: measure borda-to-carrier-loss distance.
    cur = ~cur;
    put(cur);
    gap = 0;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (bus.borda) begin seen = 1; gap = 0; end
      else if (seen) gap++;
      if (seen && !bus.carrier) break;
    end
    chk("loss_gap",    gap,              MAX_HALF);
    chk("loss_bitout", int'(bus.bitout), 1);
    chk("model_loss_carrier", int'(m_carrier), 0);

    square(20, 6);
    chk("relock_bitout",  int'(bus.bitout),  0);
    chk("relock_carrier", int'(bus.carrier), 1);

    pulse_reset("midlock");
    square(20, 6);
    chk("post_rst_bitout", int'(bus.bitout), 0);

    for (int k = 0; k < 200; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) pulse_reset("rand_rst");
      else if (r < 7) begin
        cur = ~cur;
        repeat ($urandom_range(190, 260)) put(cur);
      end
      else if (r < 15) glitch_half(int'($urandom_range(10, 50)));
      else half(int'($urandom_range(1, 60)));
    end
    repeat (5) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
